// File: rtl/linear_layer_start_fifo_srl.sv
// Start-token/data FIFO built on a DEPTH-entry SRL shift array with FWFT read-out.
// Optional output register enabled by defining START_FIFO_DOUT_REG_EN.
module linear_layer_start_fifo_srl #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 1,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  if_full_n,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_empty_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout
);

    // Array is sized to the full address space so any read address is in range.
    localparam int                SRL_SZ  = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] C_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] r_srl [SRL_SZ];
    logic [ADDR_WIDTH:0]   r_count;
    logic [ADDR_WIDTH:0]   w_count_next;
    logic                  r_full_n;
    logic                  r_srl_ne;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_srl_dout;
    logic                  w_push;
    logic                  w_srl_pop;

    assign w_push = if_write & if_write_ce & r_full_n;

    always_comb begin
        w_addr = '0;
        if (r_count != '0) begin
            w_addr = ADDR_WIDTH'(r_count - 1'b1);
        end
    end

    assign w_srl_dout = r_srl[w_addr];

    // Newest entry lands in slot 0; the oldest sits at count-1.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_srl[0] <= if_din;
            for (int i = 1; i < SRL_SZ; i++) begin
                r_srl[i] <= r_srl[i-1];
            end
        end
    end

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_srl_pop) begin
            w_count_next = r_count + 1'b1;
        end else if (!w_push && w_srl_pop) begin
            w_count_next = r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count  <= '0;
            r_full_n <= 1'b1;
            r_srl_ne <= 1'b0;
        end else begin
            r_count  <= w_count_next;
            r_full_n <= (w_count_next != C_DEPTH);
            r_srl_ne <= (w_count_next != '0);
        end
    end

    assign if_full_n = r_full_n;

`ifdef START_FIFO_DOUT_REG_EN
    logic                  r_dout_vld;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  w_pop;

    assign w_pop     = if_read & if_read_ce & r_dout_vld;
    // Refill the output register whenever it is free or being drained this cycle.
    assign w_srl_pop = r_srl_ne & (~r_dout_vld | w_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dout_vld <= 1'b0;
            r_dout     <= '0;
        end else if (w_srl_pop) begin
            r_dout_vld <= 1'b1;
            r_dout     <= w_srl_dout;
        end else if (w_pop) begin
            r_dout_vld <= 1'b0;
        end
    end

    assign if_empty_n = r_dout_vld;
    assign if_dout    = r_dout;
`else
    assign w_srl_pop  = if_read & if_read_ce & r_srl_ne;
    assign if_empty_n = r_srl_ne;
    assign if_dout    = w_srl_dout;
`endif

endmodule

// File: tb/tb_linear_layer_start_fifo_srl.sv
// Self-checking bench for linear_layer_start_fifo_srl: directed scenarios plus
// randomized traffic compared against a queue-based reference model.
`timescale 1ns/1ps
module tb_linear_layer_start_fifo_srl;
    localparam int DW = 8;
    localparam int AW = 1;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_full_n;
    logic          if_write_ce;
    logic          if_write;
    logic [DW-1:0] if_din;
    logic          if_empty_n;
    logic          if_read_ce;
    logic          if_read;
    logic [DW-1:0] if_dout;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mq[$];
    logic          m_ovld = 1'b0;
    logic [DW-1:0] m_odata = '0;

    linear_layer_start_fifo_srl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .if_full_n(if_full_n), .if_write_ce(if_write_ce), .if_write(if_write), .if_din(if_din),
        .if_empty_n(if_empty_n), .if_read_ce(if_read_ce), .if_read(if_read), .if_dout(if_dout)
    );

    always #5 clk = ~clk;

    function automatic logic exp_full_n();
        return mq.size() != DEPTH;
    endfunction

    function automatic logic exp_empty_n();
`ifdef START_FIFO_DOUT_REG_EN
        return m_ovld;
`else
        return mq.size() != 0;
`endif
    endfunction

    function automatic logic [DW-1:0] exp_dout();
`ifdef START_FIFO_DOUT_REG_EN
        return m_odata;
`else
        return (mq.size() != 0) ? mq[0] : '0;
`endif
    endfunction

    // Reference behaviour: mq is the storage (front = oldest), handshakes gated by model flags.
    function automatic void model_step();
        logic push, pop, load;
        logic [DW-1:0] d;
        push = if_write & if_write_ce & exp_full_n();
        pop  = if_read & if_read_ce & exp_empty_n();
        if (reset) begin
            mq.delete();
            m_ovld  = 1'b0;
            m_odata = '0;
            return;
        end
`ifdef START_FIFO_DOUT_REG_EN
        load = (mq.size() != 0) && (!m_ovld || pop);
        d = '0;
        if (load) d = mq.pop_front();
        if (push) mq.push_back(if_din);
        if (load) begin
            m_ovld  = 1'b1;
            m_odata = d;
        end else if (pop) begin
            m_ovld = 1'b0;
        end
`else
        load = 1'b0;
        d = '0;
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back(if_din);
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic drive(input logic w, input logic wce, input logic [DW-1:0] d,
                         input logic r, input logic rce, input logic rst);
        if_write = w; if_write_ce = wce; if_din = d;
        if_read = r; if_read_ce = rce; reset = rst;
        tick();
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && exp_empty_n(); i++) drive(0, 0, '0, 1, 1, 0);
        drive(0, 0, '0, 0, 0, 0);
    endtask

    task automatic test_reset();
        drive(0, 0, '0, 0, 0, 1);
        drive(0, 0, '0, 0, 0, 1);
        checks++; if (if_full_n !== 1'b1) begin errors++; $display("FAIL rst_full_n got=%b exp=1", if_full_n); end
        checks++; if (if_empty_n !== 1'b0) begin errors++; $display("FAIL rst_empty_n got=%b exp=0", if_empty_n); end
        drive(1, 1, 8'h33, 0, 0, 0);
        drive(1, 1, 8'h44, 0, 0, 0);
        drive(1, 1, 8'h55, 1, 1, 1);
        checks++; if (if_full_n !== 1'b1 || if_empty_n !== 1'b0) begin
            errors++; $display("FAIL midrst_flags full_n=%b empty_n=%b exp 1/0", if_full_n, if_empty_n); end
        drive(1, 1, 8'h66, 1, 1, 1);
        drive(1, 1, 8'h01, 0, 0, 0);
        drive(0, 0, '0, 0, 0, 0);
        checks++; if (if_empty_n !== 1'b1 || if_dout !== 8'h01) begin
            errors++; $display("FAIL rst_readback empty_n=%b dout=%h exp 1/01", if_empty_n, if_dout); end
        drive(0, 0, '0, 1, 1, 0);
        checks++; if (if_empty_n !== 1'b0) begin errors++; $display("FAIL rst_only_one empty_n=%b exp=0", if_empty_n); end
    endtask

    task automatic test_fill_drain();
        drive(1, 1, 8'hA1, 0, 0, 0);
        drive(1, 1, 8'hB2, 0, 0, 0);
`ifndef START_FIFO_DOUT_REG_EN
        checks++; if (if_full_n !== 1'b0) begin errors++; $display("FAIL fill_full_n got=%b exp=0", if_full_n); end
`endif
        drive(1, 1, 8'hC3, 0, 0, 0);
        checks++; if (if_dout !== 8'hA1 || if_empty_n !== 1'b1) begin
            errors++; $display("FAIL drain0 dout=%h empty_n=%b exp a1/1", if_dout, if_empty_n); end
        drive(0, 0, '0, 1, 1, 0);
        checks++; if (if_dout !== 8'hB2 || if_empty_n !== 1'b1) begin
            errors++; $display("FAIL drain1 dout=%h empty_n=%b exp b2/1", if_dout, if_empty_n); end
        drive(0, 0, '0, 1, 1, 0);
`ifndef START_FIFO_DOUT_REG_EN
        checks++; if (if_empty_n !== 1'b0) begin errors++; $display("FAIL drain_empty empty_n=%b exp=0", if_empty_n); end
`endif
        drain();
    endtask

    task automatic test_latency();
        drive(1, 1, 8'h5A, 0, 0, 0);
`ifdef START_FIFO_DOUT_REG_EN
        checks++; if (if_empty_n !== 1'b0) begin errors++; $display("FAIL lat_early empty_n=%b exp=0", if_empty_n); end
        drive(0, 0, '0, 0, 0, 0);
`endif
        checks++; if (if_empty_n !== 1'b1 || if_dout !== 8'h5A) begin
            errors++; $display("FAIL latency empty_n=%b dout=%h exp 1/5a", if_empty_n, if_dout); end
        drain();
    endtask

    task automatic test_simultaneous();
        drive(1, 1, 8'h11, 0, 0, 0);
`ifdef START_FIFO_DOUT_REG_EN
        drive(0, 0, '0, 0, 0, 0);
`endif
        drive(1, 1, 8'h22, 1, 1, 0);
`ifdef START_FIFO_DOUT_REG_EN
        drive(0, 0, '0, 0, 0, 0);
`endif
        checks++; if (if_dout !== 8'h22 || if_empty_n !== 1'b1 || if_full_n !== 1'b1) begin
            errors++; $display("FAIL simul dout=%h empty_n=%b full_n=%b exp 22/1/1", if_dout, if_empty_n, if_full_n); end
        drive(0, 0, '0, 1, 1, 0);
        checks++; if (if_empty_n !== 1'b0) begin errors++; $display("FAIL simul_cnt1 empty_n=%b exp=0", if_empty_n); end
        drain();
    endtask

    task automatic test_full_push_pop();
        drive(1, 1, 8'h01, 0, 0, 0);
        drive(1, 1, 8'h02, 0, 0, 0);
        drive(1, 1, 8'h03, 1, 1, 0);
        checks++; if (if_full_n !== 1'b1 || if_dout !== 8'h02) begin
            errors++; $display("FAIL fullpp full_n=%b dout=%h exp 1/02", if_full_n, if_dout); end
`ifndef START_FIFO_DOUT_REG_EN
        drive(0, 0, '0, 1, 1, 0);
        checks++; if (if_empty_n !== 1'b0) begin errors++; $display("FAIL fullpp_lost empty_n=%b exp=0", if_empty_n); end
`endif
        drain();
    endtask

    task automatic test_ce_gating();
        logic [DW-1:0] d0;
        drive(1, 1, 8'h7E, 0, 0, 0);
        drive(0, 0, '0, 0, 0, 0);
        d0 = 8'h7E;
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 8'h99, 1, 0, 0);
            checks++; if (if_empty_n !== 1'b1 || if_dout !== d0 || if_full_n !== 1'b1) begin
                errors++; $display("FAIL ce_gate[%0d] empty_n=%b dout=%h full_n=%b exp 1/%h/1", i, if_empty_n, if_dout, if_full_n, d0); end
        end
        drain();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 5) != 0, DW'($urandom),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 5) != 0, $urandom_range(0, 60) == 0);
            checks++; if (if_full_n !== exp_full_n()) begin
                errors++; $display("FAIL rnd_full_n cyc=%0d got=%b exp=%b", c, if_full_n, exp_full_n()); end
            checks++; if (if_empty_n !== exp_empty_n()) begin
                errors++; $display("FAIL rnd_empty_n cyc=%0d got=%b exp=%b", c, if_empty_n, exp_empty_n()); end
            if (exp_empty_n()) begin
                checks++; if (if_dout !== exp_dout()) begin
                    errors++; $display("FAIL rnd_dout cyc=%0d got=%h exp=%h", c, if_dout, exp_dout()); end
            end
        end
        drain();
    endtask

    initial begin
        reset = 1'b1; if_write = 0; if_write_ce = 0; if_din = '0; if_read = 0; if_read_ce = 0;
        @(negedge clk);
        test_reset();
        test_fill_drain();
        test_latency();
        test_simultaneous();
        test_full_push_pop();
        test_ce_gating();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
